ripple_carry_adder4: RTL and testbench



---
 rtl/ripple_carry_adder4.sv | 87 ++++++++
 tb/tb_ripple_carry_adder4.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder4.sv
// Registered WIDTH-bit ripple-carry adder: full-adder slice chain, one-cycle
// registered sum, carry-out and two's-complement overflow.
module ripple_carry_adder4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid
);

    // One slice: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (c & (a ^ b));
        return {co, s};
    endfunction

    logic [WIDTH-1:0] next_sum;
    logic             next_cout;
    logic             next_ovf;

    // Stage p0: combinational carry chain, Cin ripples through every slice.
    always_comb begin : carry_chain
        logic       carry;
        logic       carry_into_msb;
        logic [1:0] slice;
        carry          = Cin;
        carry_into_msb = Cin;
        slice          = 2'b00;
        next_sum       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry_into_msb = carry;
            slice          = full_add(A[i], B[i], carry);
            next_sum[i]    = slice[0];
            carry          = slice[1];
        end
        next_cout = carry;
        next_ovf  = carry_into_msb ^ carry;
    end

    logic [WIDTH-1:0] sum_p1_d, sum_p1_q;
    logic             cout_p1_d, cout_p1_q;
    logic             ovf_p1_d, ovf_p1_q;
    logic             vld_p1_d, vld_p1_q;

    always_comb begin
        sum_p1_d  = sum_p1_q;
        cout_p1_d = cout_p1_q;
        ovf_p1_d  = ovf_p1_q;
        vld_p1_d  = in_valid;
        if (in_valid) begin
            sum_p1_d  = next_sum;
            cout_p1_d = next_cout;
            ovf_p1_d  = next_ovf;
        end
    end

    // Stage p1: result registers, held while no new operands arrive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p1_q  <= '0;
            cout_p1_q <= 1'b0;
            ovf_p1_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
        end else begin
            sum_p1_q  <= sum_p1_d;
            cout_p1_q <= cout_p1_d;
            ovf_p1_q  <= ovf_p1_d;
            vld_p1_q  <= vld_p1_d;
        end
    end

    assign Sum       = sum_p1_q;
    assign Cout      = cout_p1_q;
    assign Ovf       = ovf_p1_q;
    assign out_valid = vld_p1_q;

endmodule

// File: tb/tb_ripple_carry_adder4.sv
// Directed and sweep bench for ripple_carry_adder4 at WIDTH=4 and WIDTH=8.
module tb_ripple_carry_adder4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a4, b4;
    logic       cin4;
    logic [3:0] sum4;
    logic       cout4, ovf4, ovld4;
    logic [7:0] a8, b8;
    logic       cin8;
    logic [7:0] sum8;
    logic       cout8, ovf8, ovld8;

    int n_checks;
    int n_errors;

    ripple_carry_adder4 #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(a4), .B(b4), .Cin(cin4),
        .Sum(sum4), .Cout(cout4), .Ovf(ovf4), .out_valid(ovld4)
    );

    ripple_carry_adder4 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(a8), .B(b8), .Cin(cin8),
        .Sum(sum8), .Cout(cout8), .Ovf(ovf8), .out_valid(ovld8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                          input logic [3:0] es, input logic ec, input logic eo, input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        a4 = a; b4 = b; cin4 = ci;
        @(posedge clk);
        #1;
        check({tag, " sum"}, 64'(sum4), 64'(es));
        check({tag, " cout"}, 64'(cout4), 64'(ec));
        check({tag, " ovf"}, 64'(ovf4), 64'(eo));
        check({tag, " out_valid"}, 64'(ovld4), 64'd1);
    endtask

    task automatic idle4(input logic [3:0] es, input logic ec, input logic eo, input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
        @(posedge clk);
        #1;
        check({tag, " held"}, {60'd0, ovld4, ovf4, cout4, sum4[0]} | 64'(sum4) << 4,
              {60'd0, 1'b0, eo, ec, es[0]} | 64'(es) << 4);
    endtask

    initial begin
        logic [4:0] full;
        logic [3:0] es;
        logic       eo;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        apply4(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, "pre_reset");
        // Assert reset mid-cycle while a new operand set is being presented.
        @(negedge clk);
        in_valid = 1'b1; a4 = 4'd3; b4 = 4'd3; cin4 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset sum", 64'(sum4), 64'd0);
        check("reset cout", 64'(cout4), 64'd0);
        check("reset ovf", 64'(ovf4), 64'd0);
        check("reset out_valid", 64'(ovld4), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_reset idle", {60'd0, ovld4, ovf4, cout4, 1'b0} | 64'(sum4) << 4, 64'd0);
        end

        apply4(4'd3, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0, "3+3");
        idle4(4'd6, 1'b0, 1'b0, "3+3 one_cycle");
        apply4(4'd5, 4'd2, 1'b1, 4'b1000, 1'b0, 1'b1, "5+2+1");
        apply4(4'b1010, 4'b0001, 1'b0, 4'b1011, 1'b0, 1'b0, "a+1 b2b");
        apply4(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, "15+15+1");
        apply4(4'd15, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, "15+0+1");
        apply4(4'd8, 4'd8, 1'b0, 4'd0, 1'b1, 1'b1, "8+8");
        apply4(4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1, "7+1");
        for (int i = 0; i < 3; i++) idle4(4'd8, 1'b0, 1'b1, "hold");

        // Exhaustive WIDTH=4 sweep; overflow from operand/result sign rule.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    full = 5'(a + b + c);
                    es = full[3:0];
                    eo = (a[3] == b[3]) && (es[3] != a[3]);
                    @(negedge clk);
                    in_valid = 1'b1;
                    a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c);
                    @(posedge clk);
                    #1;
                    check("sweep4", {58'd0, ovld4, ovf4, cout4, sum4}, {58'd0, 1'b1, eo, full});
                end
            end
        end

        // Random WIDTH=8 vectors; overflow from signed range.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            int         sfull;
            logic [8:0] ufull;
            logic       e8ovf;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra = 8'h7f; rb = 8'h00; rc = 1'b1; end
            if (i == 1) begin ra = 8'h80; rb = 8'hff; rc = 1'b0; end
            if (i == 2) begin ra = 8'hff; rb = 8'hff; rc = 1'b1; end
            ufull = 9'(ra) + 9'(rb) + 9'(rc);
            sfull = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
            e8ovf = (sfull > 127) || (sfull < -128);
            @(negedge clk);
            in_valid = 1'b1;
            a8 = ra; b8 = rb; cin8 = rc;
            @(posedge clk);
            #1;
            check("rand8", {53'd0, ovld8, ovf8, cout8, sum8}, {53'd0, 1'b1, e8ovf, ufull});
        end

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("final out_valid4", 64'(ovld4), 64'd0);
        check("final out_valid8", 64'(ovld8), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
